// File: rtl/bcd_digit_entry.sv
// bcd_digit_entry: calculator-style entry of a 3-digit packed-BCD operand.
// Digits shift in at the units position. A committed operand is held on
// num_out under a valid/ack handshake until the consumer acknowledges it.
//
// Handshakes:
//   digit side  - a digit transfers on a cycle where digit_valid and
//                 digit_ready are both high; digit_ready depends only on state.
//   operand side - num_valid rises the cycle after a commit and stays high, with
//                 num_out frozen, until a cycle with num_ack high; it drops the
//                 following cycle.
//
// state_dbg encoding: 0 = IDLE, 1 = ENTRY, 2 = FULL, 3 = PEND.

module bcd_digit_entry #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TMR_W          = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit_in,
    input  logic        digit_valid,
    output logic        digit_ready,
    input  logic        enter,
    input  logic        clr,
    output logic [11:0] num_out,
    output logic        num_valid,
    input  logic        num_ack,
    output logic [11:0] entry_val,
    output logic [1:0]  digit_count,
    output logic        err,
    output logic        timeout,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2,
        PEND  = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_next;
    logic [11:0]       num_out_next;
    logic              num_valid_next;
    logic [11:0]       entry_next;
    logic [1:0]        count_next;
    logic              err_next;
    logic              timeout_next;
    logic [TMR_W-1:0]  timer, timer_next;

    logic              accept;
    logic              bad_digit;
    logic [11:0]       shifted;
    logic [1:0]        count_inc;

    // digit_ready is the only combinational output: high while room remains.
    assign digit_ready = (state == IDLE) || (state == ENTRY);
    assign state_dbg   = state;

    assign accept    = digit_valid && digit_ready && (digit_in <= 4'd9);
    assign bad_digit = digit_valid && digit_ready && (digit_in > 4'd9);
    assign shifted   = {entry_val[7:0], digit_in};
    assign count_inc = digit_count + 2'd1;

    // Registered state and outputs; rst returns everything to an empty IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            num_out     <= 12'h000;
            num_valid   <= 1'b0;
            entry_val   <= 12'h000;
            digit_count <= 2'd0;
            err         <= 1'b0;
            timeout     <= 1'b0;
            timer       <= '0;
        end else begin
            state       <= state_next;
            num_out     <= num_out_next;
            num_valid   <= num_valid_next;
            entry_val   <= entry_next;
            digit_count <= count_next;
            err         <= err_next;
            timeout     <= timeout_next;
            timer       <= timer_next;
        end
    end

    // Next-state decode in priority order: clr > enter > ack/digit/timer.
    always_comb begin
        state_next     = state;
        num_out_next   = num_out;
        num_valid_next = num_valid;
        entry_next     = entry_val;
        count_next     = digit_count;
        err_next       = bad_digit;
        timeout_next   = 1'b0;
        timer_next     = timer;

        if (clr) begin
            // num_out keeps its last value so the consumer never sees a glitch.
            entry_next     = 12'h000;
            count_next     = 2'd0;
            num_valid_next = 1'b0;
            timer_next     = '0;
            state_next     = IDLE;
        end else if (enter && (state != PEND)) begin
            // A digit arriving on the same edge is folded into the commit.
            num_out_next   = accept ? shifted : entry_val;
            num_valid_next = 1'b1;
            entry_next     = 12'h000;
            count_next     = 2'd0;
            timer_next     = '0;
            state_next     = PEND;
        end else if (state == PEND) begin
            if (num_ack) begin
                num_valid_next = 1'b0;
                state_next     = IDLE;
            end
        end else if (accept) begin
            entry_next = shifted;
            count_next = count_inc;
            timer_next = '0;
            state_next = (count_inc == 2'd3) ? FULL : ENTRY;
        end else if (state != IDLE) begin
            // Inactivity timer runs only while a partial entry exists.
            if (timer == TIMER_LAST) begin
                entry_next   = 12'h000;
                count_next   = 2'd0;
                timeout_next = 1'b1;
                timer_next   = '0;
                state_next   = IDLE;
            end else begin
                timer_next = timer + TMR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed testbench for bcd_digit_entry with a short inactivity timeout.

module tb_bcd_digit_entry;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        digit_ready;
    logic        enter;
    logic        clr;
    logic [11:0] num_out;
    logic        num_valid;
    logic        num_ack;
    logic [11:0] entry_val;
    logic [1:0]  digit_count;
    logic        err;
    logic        timeout;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    bcd_digit_entry #(.TIMEOUT_CYCLES(TO), .TMR_W(26)) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .enter       (enter),
        .clr         (clr),
        .num_out     (num_out),
        .num_valid   (num_valid),
        .num_ack     (num_ack),
        .entry_val   (entry_val),
        .digit_count (digit_count),
        .err         (err),
        .timeout     (timeout),
        .state_dbg   (state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one clock edge, then settle 1 ns so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        digit_in    = 4'd0;
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        step();
        enter = 1'b0;
    endtask

    task automatic pulse_ack();
        num_ack = 1'b1;
        step();
        num_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_num_out"}, num_out, 12'h000);
        chk1({tag, "_num_valid"}, num_valid, 1'b0);
        chk({tag, "_entry_val"}, entry_val, 12'h000);
        chk({tag, "_count"}, {10'd0, digit_count}, 12'd0);
        chk1({tag, "_err"}, err, 1'b0);
        chk1({tag, "_timeout"}, timeout, 1'b0);
        chk1({tag, "_ready"}, digit_ready, 1'b1);
        chk({tag, "_state"}, {10'd0, state_dbg}, 12'd0);
    endtask

    // directed stimulus
    initial begin
        int cycles;
        rst         = 1'b1;
        digit_in    = 4'd0;
        digit_valid = 1'b0;
        enter       = 1'b0;
        clr         = 1'b0;
        num_ack     = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_reset_state("reset");

        // 4,0,7 then enter
        send_digit(4'd4);
        chk("d4_entry", entry_val, 12'h004);
        chk("d4_count", {10'd0, digit_count}, 12'd1);
        chk("d4_state", {10'd0, state_dbg}, 12'd1);
        send_digit(4'd0);
        chk("d0_entry", entry_val, 12'h040);
        send_digit(4'd7);
        chk("d7_entry", entry_val, 12'h407);
        chk("d7_count", {10'd0, digit_count}, 12'd3);
        chk1("full_ready", digit_ready, 1'b0);
        chk("full_state", {10'd0, state_dbg}, 12'd2);
        pulse_enter();
        chk("commit_num", num_out, 12'h407);
        chk1("commit_valid", num_valid, 1'b1);
        chk("commit_entry", entry_val, 12'h000);
        chk("commit_count", {10'd0, digit_count}, 12'd0);
        chk("pend_state", {10'd0, state_dbg}, 12'd3);

        // PEND ignores digits and enter
        chk1("pend_ready", digit_ready, 1'b0);
        send_digit(4'd5);
        chk1("pend_digit_err", err, 1'b0);
        chk("pend_digit_entry", entry_val, 12'h000);
        pulse_enter();
        chk("pend_enter_num", num_out, 12'h407);
        chk1("pend_enter_valid", num_valid, 1'b1);
        pulse_ack();
        chk1("ack_valid", num_valid, 1'b0);
        chk("ack_state", {10'd0, state_dbg}, 12'd0);
        chk("ack_num_hold", num_out, 12'h407);

        // invalid digit, then overflow attempt
        send_digit(4'hA);
        chk1("bad_err", err, 1'b1);
        chk("bad_count", {10'd0, digit_count}, 12'd0);
        step();
        chk1("bad_err_pulse", err, 1'b0);
        send_digit(4'd1);
        send_digit(4'd2);
        send_digit(4'd3);
        send_digit(4'd9);
        chk("over_entry", entry_val, 12'h123);
        chk("over_count", {10'd0, digit_count}, 12'd3);
        chk1("over_err", err, 1'b0);
        pulse_enter();
        chk("commit123_num", num_out, 12'h123);
        pulse_ack();

        // digit and enter on the same edge
        digit_in    = 4'd8;
        digit_valid = 1'b1;
        enter       = 1'b1;
        step();
        digit_valid = 1'b0;
        enter       = 1'b0;
        chk("same_cycle_num", num_out, 12'h008);
        chk1("same_cycle_valid", num_valid, 1'b1);
        chk("same_cycle_entry", entry_val, 12'h000);
        pulse_ack();

        // clr and enter on the same edge: clr wins
        send_digit(4'd5);
        clr   = 1'b1;
        enter = 1'b1;
        step();
        clr   = 1'b0;
        enter = 1'b0;
        chk("clr_state", {10'd0, state_dbg}, 12'd0);
        chk1("clr_valid", num_valid, 1'b0);
        chk("clr_entry", entry_val, 12'h000);
        chk("clr_num_hold", num_out, 12'h008);

        // enter in IDLE commits 000
        pulse_enter();
        chk("idle_commit_num", num_out, 12'h000);
        chk1("idle_commit_valid", num_valid, 1'b1);
        // clr while PEND drops num_valid and keeps num_out
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk1("clr_pend_valid", num_valid, 1'b0);
        chk("clr_pend_state", {10'd0, state_dbg}, 12'd0);

        // inactivity timeout: pulse exactly TO cycles after the accepting edge
        send_digit(4'd6);
        chk("to_entry", entry_val, 12'h006);
        cycles = 0;
        for (int i = 0; i < 4 * TO; i++) begin
            step();
            cycles++;
            if (timeout === 1'b1) break;
        end
        chk1("to_pulse", timeout, 1'b1);
        chk("to_latency", 12'(cycles), 12'(TO));
        chk("to_entry_clr", entry_val, 12'h000);
        chk("to_count_clr", {10'd0, digit_count}, 12'd0);
        chk("to_state", {10'd0, state_dbg}, 12'd0);
        step();
        chk1("to_pulse_end", timeout, 1'b0);

        // enter on the timeout edge wins
        send_digit(4'd6);
        for (int i = 0; i < TO - 1; i++) step();
        chk1("to_pre_enter", timeout, 1'b0);
        pulse_enter();
        chk1("to_enter_nopulse", timeout, 1'b0);
        chk1("to_enter_valid", num_valid, 1'b1);
        chk("to_enter_num", num_out, 12'h006);
        pulse_ack();

        // reset mid-entry
        send_digit(4'd1);
        send_digit(4'd2);
        chk("mid_count", {10'd0, digit_count}, 12'd2);
        do_reset();
        chk_reset_state("rst_mid");

        // reset while PEND
        send_digit(4'd3);
        pulse_enter();
        chk("pre_rst_num", num_out, 12'h003);
        do_reset();
        chk_reset_state("rst_pend");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
